mdu_ctrl: RTL

//  Multi-cycle multiply/divide unit with HI/LO register file and sequencer, executing
//  the mult/multu/div/divu/mthi/mtlo/mfhi/mflo group flagged by the instruction decoder.

---
 rtl/mdu_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit with HI/LO registers and a fixed-latency sequencer.
// Optional MDU_CANCEL_EN: a flush while an op is running aborts it without committing.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        mult,
   input  logic        multu,
   input  logic        div,
   input  logic        divu,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic        flush,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic          r_busy;
   logic [31:0]   r_hi, r_lo;
   logic [31:0]   r_pend_hi, r_pend_lo;
   logic          r_pend_we;

   logic          w_is_idle, w_mul_op, w_issue, w_commit;
   logic [63:0]   w_ext_a, w_ext_b, w_prod;
   logic          w_neg_a, w_neg_b;
   logic [31:0]   w_mag_a, w_mag_b, w_dvsr, w_q_mag, w_r_mag, w_quot, w_rem;
   logic [31:0]   w_res_hi, w_res_lo;
   logic          w_res_we;

   assign w_is_idle = (r_state == IDLE);
   assign w_mul_op  = mult | multu;
   assign w_issue   = (mult | multu | div | divu) & ~flush & w_is_idle;

   // Lower 64 bits of the product are the same for signed and unsigned once the
   // operands are sign- or zero-extended to 64 bits.
   assign w_ext_a = {{32{mult & a[31]}}, a};
   assign w_ext_b = {{32{mult & b[31]}}, b};
   assign w_prod  = w_ext_a * w_ext_b;

   // Signed division on magnitudes keeps 0x80000000 / -1 well defined (wraps back).
   assign w_neg_a = div & a[31];
   assign w_neg_b = div & b[31];
   assign w_mag_a = w_neg_a ? (~a + 32'd1) : a;
   assign w_mag_b = w_neg_b ? (~b + 32'd1) : b;
   assign w_dvsr  = (b == 32'd0) ? 32'd1 : w_mag_b;
   assign w_q_mag = w_mag_a / w_dvsr;
   assign w_r_mag = w_mag_a % w_dvsr;
   assign w_quot  = (w_neg_a ^ w_neg_b) ? (~w_q_mag + 32'd1) : w_q_mag;
   assign w_rem   = w_neg_a ? (~w_r_mag + 32'd1) : w_r_mag;

   assign w_res_hi = w_mul_op ? w_prod[63:32] : w_rem;
   assign w_res_lo = w_mul_op ? w_prod[31:0]  : w_quot;
   assign w_res_we = w_mul_op | (b != 32'd0);

   always_comb begin
      w_state_nxt = r_state;
      w_commit    = 1'b0;
      case (r_state)
         IDLE: if (w_issue) w_state_nxt = RUN;
         RUN: begin
`ifdef MDU_CANCEL_EN
            if (flush) begin
               w_state_nxt = IDLE;
            end else
`endif
            if (r_cnt == '0) begin
               w_commit    = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
         r_pend_hi <= 32'd0;
         r_pend_lo <= 32'd0;
         r_pend_we <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt == RUN);
         if (w_issue) begin
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
            r_pend_we <= w_res_we;
            r_cnt     <= w_mul_op ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
         end else if (!w_is_idle && r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
         end
         // Commit happens only in RUN and moves only in IDLE, so they never collide.
         if (w_commit && r_pend_we) begin
            r_hi <= r_pend_hi;
            r_lo <= r_pend_lo;
         end
         if (w_is_idle && !flush) begin
            if (mthi) r_hi <= a;
            if (mtlo) r_lo <= a;
         end
      end
   end

   assign busy = r_busy;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule
